// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver: line levels, default
// divisor and the state encoding used by both the Rx and Tx sides.
`timescale 1ns/1ps
package uart_byte_rx_pkg;

    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;
    localparam int   DEFAULT_BPS_DIV = 5208;   // 50 MHz / 9600 bps
    localparam int   DIV_W           = 16;
    localparam int   DATA_W          = 8;
    localparam int   BIT_IDX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Terminal count for a divider span of 'cycles' clock cycles.
    function automatic logic [DIV_W-1:0] div_last(input int cycles);
        return DIV_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized signal. All flops reset to
// the idle (high) line level so reset release never fakes a start edge.
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic CLK,
    input  logic RST,
    input  logic Rs232_Rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [1:0] sync_reg;
    logic       rx_d_reg;

    // Metastability chain followed by a one-cycle delay for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_reg <= 2'b11;
            rx_d_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], Rs232_Rx};
            rx_d_reg <= sync_reg[1];
        end
    end

    assign rx_s    = sync_reg[1];
    assign rx_fall = rx_d_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 LSB-first serial byte receiver. Detects a start edge, samples the
// start bit at half a bit period, then every data bit and the stop bit at
// mid-bit. Good frames update Data_Byte with a one-cycle Rx_Done; a low
// stop bit gives a one-cycle Frame_Err and the receiver waits for the line
// to return high before listening again.
`timescale 1ns/1ps
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int BPS_DIV  = DEFAULT_BPS_DIV,
    parameter int HALF_DIV = BPS_DIV / 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rs232_Rx,
    output logic [DATA_W-1:0] Data_Byte,
    output logic              Rx_Done,
    output logic              Frame_Err,
    output logic              Rx_State
);

    localparam logic [DIV_W-1:0] HALF_LAST = div_last(HALF_DIV);
    localparam logic [DIV_W-1:0] BIT_LAST  = div_last(BPS_DIV);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

    logic rx_s;
    logic rx_fall;

    uart_state_e          state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [BIT_IDX_W-1:0] bit_reg, bit_next;
    logic [DATA_W-1:0]    shift_reg, shift_next;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic                 done_reg, done_next;
    logic                 ferr_reg, ferr_next;

    uart_rx_sync u_sync (
        .CLK      (CLK),
        .RST      (RST),
        .Rs232_Rx (Rs232_Rx),
        .rx_s     (rx_s),
        .rx_fall  (rx_fall)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
        end
    end

    // Next-state logic: bit timing is counted from the detected start edge,
    // so every sample lands in the middle of its bit cell.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        ferr_next  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // Entry into IDLE always happens with the line high, so a
                // falling edge is the only way a new frame can begin.
                if (rx_fall) begin
                    state_next = ST_START;
                    div_next   = '0;
                end
            end

            ST_START: begin
                if (div_reg == HALF_LAST) begin
                    div_next = '0;
                    bit_next = '0;
                    // A start bit that is already high again was a glitch.
                    state_next = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (div_reg == BIT_LAST) begin
                    div_next   = '0;
                    shift_next = {rx_s, shift_reg[DATA_W-1:1]};
                    if (bit_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end

            ST_STOP: begin
                if (div_reg == BIT_LAST) begin
                    div_next = '0;
                    if (rx_s == STOP_BIT) begin
                        data_next  = shift_reg;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end

            ST_BREAK: begin
                // Hold off until the line is released so a break cannot
                // look like a stream of start bits.
                if (rx_s == STOP_BIT) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Data_Byte = data_reg;
    assign Rx_Done   = done_reg;
    assign Frame_Err = ferr_reg;
    assign Rx_State  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx at BPS_DIV=16. A serial line driver produces
// frames from their bit-level description; a monitor pairs every pulse
// with the frame that should have produced it.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int  BPS      = 16;
    localparam int  HALF     = 8;
    localparam real BIT_NS   = 160.0;              // 16 cycles of 10 ns
    // Pin start edge to visible pulse: 3 cycles to see the edge through the
    // synchronizer and edge detector, half a bit, then nine full bits.
    localparam int  DONE_LAT = 3 + HALF + 9 * BPS;

    typedef struct packed {
        logic [7:0]  b;
        logic        err;
        logic        timed;
        logic [31:0] start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       rx_state;

    uart_byte_rx #(.BPS_DIV(BPS), .HALF_DIV(HALF)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .Rs232_Rx  (rx_line),
        .Data_Byte (data_byte),
        .Rx_Done   (rx_done),
        .Frame_Err (frame_err),
        .Rx_State  (rx_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests_run = 0;
    int         tests_failed = 0;
    exp_t       exp_q[$];
    int         done_cyc_q[$];
    logic [7:0] model_byte = 8'h00;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         state_rises = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    // Drive one 8N1 frame. With align set the frame starts 1 ns after a clock
    // edge so its start cycle is known exactly; otherwise it follows on
    // directly from whatever was driven before.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input real bit_ns,
                              input logic expect_pulse, input logic timed,
                              input real extra_low_ns, input logic align);
        exp_t e;
        if (align) begin
            @(posedge clk);
            #1;
        end
        if (expect_pulse) begin
            e.b     = b;
            e.err   = ~stop_ok;
            e.timed = timed;
            e.start = cyc;
            exp_q.push_back(e);
        end
        $display("[TB] send 0x%02h stop=%0d bit=%0.1fns", b, stop_ok, bit_ns);
        rx_line = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            #(bit_ns);
        end
        rx_line = stop_ok;
        #(bit_ns);
        if (!stop_ok) begin
            #(extra_low_ns);
            rx_line = 1'b1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Pair every Rx_Done / Frame_Err pulse with the oldest outstanding frame.
    task automatic monitor();
        logic prev_pulse = 1'b0;
        logic prev_state = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pulse = 1'b0;
                prev_state = 1'b0;
            end else begin
                if (rx_state && !prev_state) state_rises++;
                if (rx_done) done_cnt++;
                if (frame_err) ferr_cnt++;
                if (rx_done || frame_err) begin
                    check_eq("pulse_width", prev_pulse, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_pulse", {rx_done, frame_err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pulse_kind", {rx_done, frame_err}, e.err ? 2'b01 : 2'b10);
                        if (e.timed) check_eq("pulse_latency", cyc - e.start, DONE_LAT);
                        if (rx_done) begin
                            check_eq("rx_state_at_done", rx_state, 0);
                            check_eq("data_byte", data_byte, e.b);
                            done_cyc_q.push_back(cyc);
                            model_byte = e.b;
                            $display("[TB] rx_done 0x%02h expected 0x%02h", data_byte, e.b);
                        end else begin
                            check_eq("data_hold_ferr", data_byte, model_byte);
                            $display("[TB] frame_err data 0x%02h", data_byte);
                        end
                    end
                end
                prev_pulse = rx_done | frame_err;
                prev_state = rx_state;
            end
        end
    endtask

    initial begin
        int d0, f0, r0;
        real bit_sk;

        fork
            monitor();
            begin
                #2ms;
                $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", data_byte, 8'h00);
        check_eq("rst_done", rx_done, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_state", rx_state, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single byte with nominal timing
        send_frame(8'h55, 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b1);
        wait_drain("drain_55");
        check_eq("byte_55", data_byte, 8'h55);

        // Back-to-back frames with no idle gap
        done_cyc_q.delete();
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b1);
        send_frame(8'h3C, 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b0);
        wait_drain("drain_b2b");
        check_eq("b2b_count", done_cyc_q.size(), 2);
        if (done_cyc_q.size() == 2) check_eq("b2b_spacing", done_cyc_q[1] - done_cyc_q[0], 10 * BPS);
        check_eq("b2b_no_ferr", ferr_cnt - f0, 0);
        check_eq("byte_3c", data_byte, 8'h3C);

        // Three-cycle glitch: start rejected
        repeat (20) @(posedge clk);
        d0 = done_cnt; f0 = ferr_cnt; r0 = state_rises;
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_eq("glitch_state_pulse", state_rises - r0, 1);
        check_eq("glitch_state_low", rx_state, 0);
        check_eq("glitch_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
        check_eq("glitch_data_hold", data_byte, 8'h3C);

        // Framing error followed by a held-low line, then a good frame
        r0 = state_rises; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, BIT_NS, 1'b1, 1'b1, 400.0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("ferr_count", ferr_cnt - f0, 1);
        check_eq("ferr_no_retrigger", state_rises - r0, 1);
        check_eq("ferr_state_low", rx_state, 0);
        check_eq("ferr_data_hold", data_byte, 8'h3C);
        send_frame(8'h7E, 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b1);
        wait_drain("drain_7e");
        check_eq("byte_7e", data_byte, 8'h7E);

        // Reset during data bit 4 of 0xF0
        repeat (10) @(posedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'hF0, 1'b1, BIT_NS, 1'b0, 1'b0, 0.0, 1'b1);
            begin
                repeat (5 * BPS + HALF + 3) @(posedge clk);
                #1 rst_n = 1'b0;
                #2;
                check_eq("midrst_data", data_byte, 8'h00);
                check_eq("midrst_done", rx_done, 0);
                check_eq("midrst_ferr", frame_err, 0);
                check_eq("midrst_state", rx_state, 0);
                model_byte = 8'h00;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        repeat (200) @(posedge clk);
        check_eq("midrst_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
        check_eq("midrst_data_after", data_byte, 8'h00);
        send_frame(8'h0F, 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b1);
        wait_drain("drain_0f");
        check_eq("byte_0f", data_byte, 8'h0F);

        // All byte values at nominal timing with random idle gaps
        d0 = done_cnt;
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_frame(8'(v), 1'b1, BIT_NS, 1'b1, 1'b1, 0.0, 1'b1);
        end
        wait_drain("drain_all");
        check_eq("all_count", done_cnt - d0, 256);

        // Random bytes with +3% and -3% bit-period skew
        for (int s = 0; s < 2; s++) begin
            bit_sk = (s == 0) ? BIT_NS * 1.03 : BIT_NS * 0.97;
            d0 = done_cnt;
            for (int k = 0; k < 24; k++) begin
                #($urandom_range(0, 50) * 1.0);
                send_frame(8'($urandom_range(0, 255)), 1'b1, bit_sk, 1'b1, 1'b0, 0.0, 1'b0);
            end
            wait_drain("drain_skew");
            check_eq("skew_count", done_cnt - d0, 24);
        end

        check_eq("ferr_total", ferr_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
